// File: rtl/matrix_multiplier_avalon_wrapper.sv
// Avalon-MM register window around a sequential unsigned matrix multiplier C = A * B.
// Operands are written in multi-lane bursts; results are read back one element per access.
module matrix_multiplier_avalon_wrapper #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int N_BANKS    = 4,
    parameter int PE_ROWS    = M,
    parameter int PE_COLS    = N,
    parameter int ID_WIDTH   = 3,
    localparam int CLK_W     = (K > 1) ? $clog2(K) : 1,
    localparam int RW        = 2 * DATA_WIDTH + CLK_W + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ID_WIDTH-1:0]           address,
    input  logic                          chipselect,
    input  logic                          read,
    input  logic                          write,
    input  logic [N_BANKS*DATA_WIDTH-1:0] writedata,
    output logic [RW-1:0]                 readdata,
    output logic                          waitrequest
);
    localparam int CW  = 2 * DATA_WIDTH + CLK_W;
    localparam int AAW = (M * K > 1) ? $clog2(M * K) : 1;
    localparam int BAW = (K * N > 1) ? $clog2(K * N) : 1;
    localparam int CAW = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int IW  = (M > 1) ? $clog2(M) : 1;
    localparam int JW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0]    I_LAST = IW'(PE_ROWS - 1);
    localparam logic [JW-1:0]    J_LAST = JW'(PE_COLS - 1);
    localparam logic [CLK_W-1:0] K_LAST = CLK_W'(K - 1);

    localparam logic [ID_WIDTH-1:0] REG_CONTROL = ID_WIDTH'(0);
    localparam logic [ID_WIDTH-1:0] REG_STATUS  = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] REG_C_ADDR  = ID_WIDTH'(2);
    localparam logic [ID_WIDTH-1:0] REG_C_DATA  = ID_WIDTH'(3);
    localparam logic [ID_WIDTH-1:0] REG_A_ADDR  = ID_WIDTH'(4);
    localparam logic [ID_WIDTH-1:0] REG_A_DATA  = ID_WIDTH'(5);
    localparam logic [ID_WIDTH-1:0] REG_B_ADDR  = ID_WIDTH'(6);
    localparam logic [ID_WIDTH-1:0] REG_B_DATA  = ID_WIDTH'(7);

    typedef enum logic {IDLE, RUN} state_t;

    logic [DATA_WIDTH-1:0]    a_mem [M*K];
    logic [DATA_WIDTH-1:0]    b_mem [K*N];
    logic [CW-1:0]            c_mem [M*N];
    logic [CAW-1:0]           c_addr;
    logic [N_BANKS*AAW-1:0]   a_addr;
    logic [N_BANKS*BAW-1:0]   b_addr;
    state_t                   state;
    logic                     done;
    logic                     top_mult_done;
    logic                     busy;
    logic [IW-1:0]            i;
    logic [JW-1:0]            j;
    logic [CLK_W-1:0]         k;
    logic [CW-1:0]            acc;

    logic                     wr_en;
    logic [AAW-1:0]           a_idx;
    logic [BAW-1:0]           b_idx;
    logic [CAW-1:0]           c_idx;
    logic [2*DATA_WIDTH-1:0]  prod_raw;
    logic [CW-1:0]            prod;

    assign wr_en         = chipselect & write;
    assign busy          = (state == RUN);
    assign top_mult_done = done;
    assign waitrequest   = 1'b0;

    always_comb begin
        a_idx    = AAW'(32'(i) * K + 32'(k));
        b_idx    = BAW'(32'(k) * N + 32'(j));
        c_idx    = CAW'(32'(i) * N + 32'(j));
        prod_raw = {{DATA_WIDTH{1'b0}}, a_mem[a_idx]} * {{DATA_WIDTH{1'b0}}, b_mem[b_idx]};
        prod     = {{CLK_W{1'b0}}, prod_raw};
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int n = 0; n < M * K; n++) a_mem[n] <= '0;
            for (int n = 0; n < K * N; n++) b_mem[n] <= '0;
            for (int n = 0; n < M * N; n++) c_mem[n] <= '0;
            c_addr <= '0;
            a_addr <= '0;
            b_addr <= '0;
            state  <= IDLE;
            done   <= 1'b0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
        end else begin
            // Host register writes; address registers are accepted even while busy
            if (wr_en) begin
                case (address)
                    REG_C_ADDR: c_addr <= writedata[CAW-1:0];
                    REG_A_ADDR: a_addr <= writedata[N_BANKS*AAW-1:0];
                    REG_B_ADDR: b_addr <= writedata[N_BANKS*BAW-1:0];
                    REG_A_DATA:
                        if (!busy) begin
                            // Later lanes overwrite earlier ones on duplicate indices
                            for (int l = 0; l < N_BANKS; l++)
                                if (32'(a_addr[l*AAW +: AAW]) < M * K)
                                    a_mem[a_addr[l*AAW +: AAW]] <= writedata[l*DATA_WIDTH +: DATA_WIDTH];
                        end
                    REG_B_DATA:
                        if (!busy) begin
                            for (int l = 0; l < N_BANKS; l++)
                                if (32'(b_addr[l*BAW +: BAW]) < K * N)
                                    b_mem[b_addr[l*BAW +: BAW]] <= writedata[l*DATA_WIDTH +: DATA_WIDTH];
                        end
                    default: ;
                endcase
            end

            // One multiply-accumulate per edge while running
            case (state)
                IDLE: begin
                    if (wr_en && address == REG_CONTROL && writedata[0]) begin
                        done  <= 1'b0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (k != K_LAST) begin
                        acc <= acc + prod;
                        k   <= k + 1'b1;
                    end else begin
                        c_mem[c_idx] <= acc + prod;
                        acc <= '0;
                        k   <= '0;
                        if (j == J_LAST) begin
                            j <= '0;
                            if (i == I_LAST) begin
                                i     <= '0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect && read) begin
            case (address)
                REG_STATUS: readdata = RW'({busy, top_mult_done});
                REG_C_ADDR: readdata = RW'(c_addr);
                REG_C_DATA: readdata = RW'(c_mem[c_addr]);
                REG_A_ADDR: readdata = RW'(a_addr);
                REG_B_ADDR: readdata = RW'(b_addr);
                default:    readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_multiplier_avalon_wrapper.sv
// Directed bench for matrix_multiplier_avalon_wrapper: reads push expected values into a
// scoreboard queue, and a negedge monitor pops and compares whenever a read is presented.
module tb_matrix_multiplier_avalon_wrapper;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [63:0] writedata;
    logic [34:0] readdata;
    logic        waitrequest;

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_q [$];
    string       name_q [$];
    logic [34:0] mon_exp;
    string       mon_name;

    logic [15:0] mat [16];
    logic [34:0] exp_c [16];

    always #5 clk = ~clk;

    matrix_multiplier_avalon_wrapper dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    // Monitor: compares every presented read against the scoreboard head
    always @(negedge clk) begin
        total++;
        if (waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL waitrequest: got %b want 0", waitrequest);
        end
        if (chipselect && read) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: addr=%0d got 0x%0h with empty queue", address, readdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (readdata !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h want 0x%0h", mon_name, readdata, mon_exp);
                end
            end
        end else begin
            total++;
            if (readdata !== 35'h0) begin
                bad++;
                $display("FAIL idle_readdata: got 0x%0h want 0x0", readdata);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [34:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    // Loads a full 4x4 operand four elements per data write (addr_reg = A_ADDR or B_ADDR)
    task automatic load_mat(input logic [2:0] addr_reg);
        logic [63:0] ad;
        logic [63:0] dt;
        for (int g = 0; g < 4; g++) begin
            ad = '0;
            dt = '0;
            for (int l = 0; l < 4; l++) begin
                ad[l*4 +: 4]   = 4'(4 * g + l);
                dt[l*16 +: 16] = mat[4 * g + l];
            end
            wr(addr_reg, ad);
            wr(3'(addr_reg + 3'd1), dt);
        end
    endtask

    task automatic run_and_wait();
        wr(3'd0, 64'h1);
        repeat (70) @(posedge clk);
        #1;
        rd(3'd1, 35'h1, "status_done");
    endtask

    task automatic check_c(input string tag);
        for (int n = 0; n < 16; n++) begin
            wr(3'd2, 64'(n));
            rd(3'd3, exp_c[n], $sformatf("%s_c%0d", tag, n));
        end
    endtask

    initial begin
        int full_tab [16] = '{90, 100, 110, 120, 202, 228, 254, 280,
                              314, 356, 398, 440, 426, 484, 542, 600};
        reset_n    = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;

        // Reset state
        rd(3'd1, 35'h0, "reset_status");
        rd(3'd3, 35'h0, "reset_c0");
        wr(3'd2, 64'h5);
        rd(3'd2, 35'h5, "c_addr_readback");
        rd(3'd3, 35'h0, "reset_c5");
        rd(3'd0, 35'h0, "control_reads0");

        // Single-element loads into A[0] and B[0]; other lanes write zeros to column/row 0
        wr(3'd4, 64'hC840);
        rd(3'd4, 35'hC840, "a_addr_readback");
        wr(3'd5, 64'h0000_0000_0000_ABCD);
        wr(3'd6, 64'hC840);
        rd(3'd6, 35'hC840, "b_addr_readback");
        wr(3'd7, 64'h0000_0000_0000_EF01);
        rd(3'd5, 35'h0, "a_data_reads0");

        // Start and check done lands exactly 64 edges after the start edge
        wr(3'd0, 64'h3);
        rd(3'd1, 35'h2, "busy_after_start");
        repeat (62) @(posedge clk);
        #1;
        rd(3'd1, 35'h2, "busy_edge63");
        rd(3'd1, 35'h1, "done_edge64");

        wr(3'd2, 64'h0);
        rd(3'd3, 35'h0A0650ECD, "c0_single");
        wr(3'd2, 64'hAB);
        rd(3'd2, 35'hB, "c_addr_low_bits");
        rd(3'd3, 35'h0, "c11_single");

        // Full check: A = B = (idx+1)
        for (int n = 0; n < 16; n++) begin
            mat[n]   = 16'(n + 1);
            exp_c[n] = 35'(full_tab[n]);
        end
        load_mat(3'd4);
        load_mat(3'd6);
        run_and_wait();
        check_c("seq");

        // Max-value operands
        for (int n = 0; n < 16; n++) begin
            mat[n]   = 16'hFFFF;
            exp_c[n] = 35'h3FFF80004;
        end
        load_mat(3'd4);
        load_mat(3'd6);
        run_and_wait();
        check_c("max");

        // Busy protection: start held two cycles, then CONTROL and A_DATA writes mid-run
        wr(3'd0, 64'h1);
        wr(3'd0, 64'h1);
        repeat (9) @(posedge clk);
        #1;
        wr(3'd0, 64'h1);
        wr(3'd5, 64'h0);
        repeat (51) @(posedge clk);
        #1;
        rd(3'd1, 35'h2, "busy_prot_edge63");
        rd(3'd1, 35'h1, "busy_prot_done");
        check_c("prot");

        // Reset mid-run abandons the multiply and clears C
        wr(3'd0, 64'h1);
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        rd(3'd1, 35'h0, "status_after_reset");
        for (int n = 0; n < 16; n++) exp_c[n] = 35'h0;
        check_c("rst");

        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_multiplier_avalon_wrapper.md
Name: matrix_multiplier_avalon_wrapper

Overview:
- Avalon-MM slave wrapping a small unsigned integer matrix multiplier, C[M×N] = A[M×K] · B[K×N].
- The host uses the register window to:
  - load A and B through multi-lane address/data registers,
  - start the multiply and poll its status,
  - read C back one element at a time.
- Sits between the system interconnect and on-chip operand/result storage.

Parameters:
- DATA_WIDTH, 16: width of A/B elements.
- M, 4: rows of A and C.
- K, 4: columns of A / rows of B.
- N, 4: columns of B and C.
- N_BANKS, 4: write lanes per A/B data write.
- PE_ROWS, M: informational only; must equal M.
- PE_COLS, N: informational only; must equal N.
- ID_WIDTH, 3: Avalon address width.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-high reset (asserted when 1).
- address  in  ID_WIDTH  register select.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  N_BANKS*DATA_WIDTH  write data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- readdata  out  RW = 2*DATA_WIDTH+CLK+1  read data, where CLK = (K>1 ? clog2(K) : 1).
- waitrequest  out  1  tied 0.

Behaviour:
- Widths:
  - CW = 2*DATA_WIDTH+CLK (C element width).
  - AAW = clog2(M*K); BAW = clog2(K*N); CAW = clog2(M*N).
- Storage:
  - A, B and C are register arrays indexed row-major: A idx = r*K+c, B idx = r*N+c, C idx = r*N+c.
  - All three arrays are cleared to 0 on reset.
- Register map (write accepted on any edge with chipselect&write):
  - 0 CONTROL:
    - wdata[0]=1 starts a multiply, ignored while busy.
    - Other bits reserved and ignored.
    - Reads 0.
  - 1 STATUS (read-only): bit0 = done, bit1 = busy, upper bits 0.
  - 2 C_ADDR: register of CAW bits, loaded from wdata[CAW-1:0]; reads back zero-extended.
  - 3 C_DATA (read-only): C[C_ADDR] zero-extended to RW.
  - 4 A_ADDR:
    - Register of N_BANKS*AAW bits from the low writedata bits.
    - Field i = lane i's element index.
    - Reads back.
  - 5 A_DATA:
    - Writes lane i data to A[field i] for every lane, in the same cycle.
    - A lane whose index is ≥ M*K is skipped.
    - On duplicate indices the highest lane wins.
    - Reads 0.
  - 6 B_ADDR: same as A_ADDR, with BAW-bit fields.
  - 7 B_DATA: same as A_DATA, targeting B with range K*N.
- Write blocking: A_DATA/B_DATA writes while busy are ignored; address-register writes are always accepted.
- Read path:
  - readdata is combinational: the mux of address when chipselect&read, else 0.
  - Zero read latency.
  - waitrequest is always 0.
- Engine FSM:
  - IDLE:
    - An accepted start clears done.
    - Sets i=j=k=0 and acc=0.
    - Moves to RUN.
  - RUN, each edge:
    - p = A[i*K+k]*B[k*N+j] (unsigned, CW bits).
    - If k<K-1: acc<=acc+p, k++.
    - Else: C[i*N+j]<=acc+p, acc<=0, k<=0, advance j then i.
    - After the last element (i=M-1, j=N-1): done<=1, go to IDLE.
- Timing:
  - The engine spends exactly M*N*K edges in RUN.
  - done rises on the M*N*K-th edge after the start edge.
- Done flag:
  - Internal net top_mult_done = done.
  - Sticky until the next accepted start.
  - busy = (state==RUN).
- Arithmetic: sums never overflow CW; no saturation.
- Reset:
  - All registers, arrays, FSM, done, busy and acc go to 0, including mid-operation.
  - A multiply in progress is abandoned and C is cleared.
- Repeated start: a CONTROL write held for two accepted cycles starts only once, because the second start is seen while busy.

Test Plan:
- Reset → STATUS reads 0x0; C_DATA at any address reads 0; readdata=0 when not reading; waitrequest=0 throughout.
- A load: A_ADDR=0xC840, A_DATA=0x0000_0000_0000_ABCD → A[0]=0xABCD and A[4]=A[8]=A[12]=0. B load: same with 0xEF01.
- CONTROL=3 → busy=1, top_mult_done rises 64 edges later, STATUS then reads 0x1.
- After that multiply:
  - C_ADDR=0x00 → C_DATA=0x0A0650ECD.
  - C_ADDR=0xAB (uses low bits, idx 11) → C_DATA=0.
- Full check: A = B = matrix with element value idx+1 → each C[r][c] equals the software product; max-value operands (0xFFFF everywhere) → every C = 4*0xFFFE0001 = 0x3FFF80004.
- Busy protection and reset:
  - Start again, then write CONTROL=1 and A_DATA mid-run → neither has any effect; result is unchanged.
  - Assert reset mid-run → STATUS=0 and C all 0.
